vga_rect_filler: RTL

Pixel-generation engine that sits directly upstream of the VGA frame-buffer write port. It accepts filled-rectangle commands through a valid/ready handshake, normalises and clips each command to the visible area, and emits one frame-buffer write per clock in raster order. It runs in the frame-buffer write clock domain, so its outputs connect straight to the buffer's write port.

---
 rtl/vga_rect_filler_pkg.sv | 28 ++
 rtl/vga_rect_filler_if.sv | 34 +++
 rtl/vga_raster_cnt.sv | 49 ++++
 rtl/vga_rect_filler.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_rect_filler_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg : shared definitions for the rectangle-fill engine.
//   HD, VD      : default visible width / height in pixels
//   COORD_BITS  : default coordinate width
//   color_t     : 2-bit pixel colour encoding used on the frame-buffer port
//   fill_state_t: fill engine FSM state encoding
// -----------------------------------------------------------------------------
package vga_pkg;

    localparam int HD         = 1280;
    localparam int VD         = 1024;
    localparam int COORD_BITS = 11;

    typedef enum logic [1:0] {
        BLACK = 2'd0,
        WHITE = 2'd1,
        BLUE  = 2'd2,
        GREEN = 2'd3
    } color_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } fill_state_t;

endpackage

// File: rtl/vga_rect_filler_if.sv
// -----------------------------------------------------------------------------
// vga_rect_filler_if : command channel of the rectangle-fill engine.
//   cmd_valid_i / cmd_ready_o : valid/ready handshake
//   cmd_x0_i..cmd_y1_i        : opposite inclusive corners, any order
//   cmd_color_i               : fill colour (color_t encoding)
//   abort_i                   : terminate the fill in progress
// Modports: master = command source, slave = fill engine.
// -----------------------------------------------------------------------------
interface vga_rect_filler_if #(
    parameter int COORD_BITS = vga_pkg::COORD_BITS
);

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic [COORD_BITS-1:0] cmd_x0_i;
    logic [COORD_BITS-1:0] cmd_y0_i;
    logic [COORD_BITS-1:0] cmd_x1_i;
    logic [COORD_BITS-1:0] cmd_y1_i;
    logic [1:0]            cmd_color_i;
    logic                  abort_i;

    modport master (
        output cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i,
        output cmd_color_i, abort_i,
        input  cmd_ready_o
    );

    modport slave (
        input  cmd_valid_i, cmd_x0_i, cmd_y0_i, cmd_x1_i, cmd_y1_i,
        input  cmd_color_i, abort_i,
        output cmd_ready_o
    );

endinterface

// File: rtl/vga_raster_cnt.sv
// -----------------------------------------------------------------------------
// vga_raster_cnt : loadable raster-order x/y counter.
//   clk, rst_n     : clock, synchronous active-low reset
//   load           : load x/y from load_x/load_y (has priority over inc)
//   inc            : advance one pixel; wraps x to xmin and bumps y at xmax
//   xmin/xmax/ymax : bounds of the current rectangle
//   x, y           : registered current position
//   last           : position is (xmax, ymax)
// -----------------------------------------------------------------------------
module vga_raster_cnt #(
    parameter int W = 11
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_x,
    input  logic [W-1:0] load_y,
    input  logic [W-1:0] xmin,
    input  logic [W-1:0] xmax,
    input  logic [W-1:0] ymax,
    output logic [W-1:0] x,
    output logic [W-1:0] y,
    output logic         last
);

    localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

    assign last = (x == xmax) && (y == ymax);

    // Position register: load, or step in raster order with row wrap
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= {W{1'b0}};
            y <= {W{1'b0}};
        end else if (load) begin
            x <= load_x;
            y <= load_y;
        end else if (inc) begin
            if (x == xmax) begin
                x <= xmin;
                y <= y + ONE;
            end else begin
                x <= x + ONE;
            end
        end
    end

endmodule

// File: rtl/vga_rect_filler.sv
// -----------------------------------------------------------------------------
// vga_rect_filler : filled-rectangle pixel generator feeding a frame-buffer
// write port, one pixel per clock in raster order.
//   clk50mhz_i, arstn_i : clock, synchronous active-low reset
//   cmd (slave)         : command handshake, corners, colour, abort
//   we_o                : frame-buffer write strobe
//   addr_x_o, addr_y_o  : pixel column / row
//   color_o             : pixel colour
//   busy_o              : engine not idle
//   done_o              : one-cycle pulse when a command completes
// All outputs are registered except cmd.cmd_ready_o.
// -----------------------------------------------------------------------------
module vga_rect_filler #(
    parameter int HD         = vga_pkg::HD,
    parameter int VD         = vga_pkg::VD,
    parameter int COORD_BITS = vga_pkg::COORD_BITS
) (
    input  logic                  clk50mhz_i,
    input  logic                  arstn_i,
    vga_rect_filler_if.slave      cmd,
    output logic                  we_o,
    output logic [COORD_BITS-1:0] addr_x_o,
    output logic [COORD_BITS-1:0] addr_y_o,
    output logic [1:0]            color_o,
    output logic                  busy_o,
    output logic                  done_o
);

    import vga_pkg::*;

    localparam logic [COORD_BITS-1:0] HD_C  = COORD_BITS'(HD);
    localparam logic [COORD_BITS-1:0] VD_C  = COORD_BITS'(VD);
    localparam logic [COORD_BITS-1:0] HD_M1 = COORD_BITS'(HD - 1);
    localparam logic [COORD_BITS-1:0] VD_M1 = COORD_BITS'(VD - 1);
    localparam logic [COORD_BITS-1:0] ZERO  = {COORD_BITS{1'b0}};

    fill_state_t           state_r;
    fill_state_t           state_next_s;

    logic [COORD_BITS-1:0] x0_r, y0_r, x1_r, y1_r;
    color_t                color_cmd_r;
    logic [COORD_BITS-1:0] xmin_r, xmax_r, ymax_r;

    logic [COORD_BITS-1:0] xmin_s, xmax_s, ymin_s, ymax_s;
    logic [COORD_BITS-1:0] xmax_clip_s, ymax_clip_s;
    logic                  offscreen_s;

    logic                  accept_s;
    logic                  load_s;
    logic                  inc_s;
    logic                  we_next_s;
    logic                  done_next_s;
    logic [1:0]            color_next_s;
    logic                  last_s;

    // Ready is combinational so a command can be taken on the first idle edge
    assign cmd.cmd_ready_o = (state_r == ST_IDLE) && arstn_i;

    // Normalise latched corners and clip the far edge to the visible area
    always_comb begin
        xmin_s      = (x0_r < x1_r) ? x0_r : x1_r;
        xmax_s      = (x0_r < x1_r) ? x1_r : x0_r;
        ymin_s      = (y0_r < y1_r) ? y0_r : y1_r;
        ymax_s      = (y0_r < y1_r) ? y1_r : y0_r;
        xmax_clip_s = (xmax_s > HD_M1) ? HD_M1 : xmax_s;
        ymax_clip_s = (ymax_s > VD_M1) ? VD_M1 : ymax_s;
        offscreen_s = (xmin_s >= HD_C) || (ymin_s >= VD_C);
    end

    // Next-state and next-output logic; outputs are registered one edge later
    always_comb begin
        state_next_s = state_r;
        accept_s     = 1'b0;
        load_s       = 1'b0;
        inc_s        = 1'b0;
        we_next_s    = 1'b0;
        done_next_s  = 1'b0;
        color_next_s = color_o;
        case (state_r)
            ST_IDLE: begin
                if (cmd.cmd_valid_i && cmd.cmd_ready_o) begin
                    accept_s     = 1'b1;
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (offscreen_s) begin
                    done_next_s  = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    load_s       = 1'b1;
                    we_next_s    = 1'b1;
                    color_next_s = color_cmd_r;
                    state_next_s = ST_FILL;
                end
            end
            ST_FILL: begin
                // The pixel on the port this cycle is the final one on abort
                if (cmd.abort_i || last_s) begin
                    done_next_s  = 1'b1;
                    state_next_s = ST_DONE;
                end else begin
                    inc_s        = 1'b1;
                    we_next_s    = 1'b1;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // FSM state, registered outputs, latched command and clipped bounds
    always_ff @(posedge clk50mhz_i) begin
        if (!arstn_i) begin
            state_r     <= ST_IDLE;
            we_o        <= 1'b0;
            done_o      <= 1'b0;
            busy_o      <= 1'b0;
            color_o     <= 2'd0;
            x0_r        <= ZERO;
            y0_r        <= ZERO;
            x1_r        <= ZERO;
            y1_r        <= ZERO;
            color_cmd_r <= BLACK;
            xmin_r      <= ZERO;
            xmax_r      <= ZERO;
            ymax_r      <= ZERO;
        end else begin
            state_r <= state_next_s;
            we_o    <= we_next_s;
            done_o  <= done_next_s;
            busy_o  <= (state_next_s != ST_IDLE);
            color_o <= color_next_s;
            if (accept_s) begin
                x0_r        <= cmd.cmd_x0_i;
                y0_r        <= cmd.cmd_y0_i;
                x1_r        <= cmd.cmd_x1_i;
                y1_r        <= cmd.cmd_y1_i;
                color_cmd_r <= color_t'(cmd.cmd_color_i);
            end
            if (load_s) begin
                xmin_r <= xmin_s;
                xmax_r <= xmax_clip_s;
                ymax_r <= ymax_clip_s;
            end
        end
    end

    // The counter registers double as the address outputs
    vga_raster_cnt #(
        .W(COORD_BITS)
    ) u_cnt (
        .clk    (clk50mhz_i),
        .rst_n  (arstn_i),
        .load   (load_s),
        .inc    (inc_s),
        .load_x (xmin_s),
        .load_y (ymin_s),
        .xmin   (xmin_r),
        .xmax   (xmax_r),
        .ymax   (ymax_r),
        .x      (addr_x_o),
        .y      (addr_y_o),
        .last   (last_s)
    );

endmodule
